data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised RV32 data-memory unit on the CPU load/store port. Owns an on-chip word RAM.
//  Performs LB/LH/LW/LBU/LHU loads, with byte-lane alignment and sign/zero extension.
//  Performs SB/SH/SW stores, either by read-modify-write or through a byte-enabled RAM.
//  Flags misaligned accesses. Sits between the execute/mem stage and the local data RAM.
// PARAMETERS
//  DEPTH_WORDS  4096  RAM depth in 32-bit words; power of two.
//  IDX_W        12    word-index width = log2(DEPTH_WORDS); RAM index = addr[IDX_W+1:2].
//  BYTE_EN      0     0 = sub-word stores by RMW (1 stall cycle); 1 = byte-enable write, no stall.
// PORTS
//  cpu_clk    in   1   core clock; all state is updated on the rising edge.
//  rst_n      in   1   asynchronous, active-low reset.
//  sig_load   in   1   load request this cycle.
//  sig_store  in   1   store request this cycle.
//  type       in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code = no-op.
//  addr       in   32  byte address; bits above IDX_W+1 are ignored (wrap modulo depth).
//  data       in   32  store data, right-aligned (byte in [7:0], half in [15:0]).
//  q          out  32  load result, extended and right-aligned; 0 when no load result is due.
//  mem_stall  out  1   core must hold the pipeline this cycle.
//  misalign   out  1   one-cycle pulse, the cycle after a misaligned request.
// BEHAVIOUR
//  Reset: FSM=IDLE; mem_stall=0; misalign=0; load-pending=0, so q=0. RAM contents are not reset.
//  Alignment: H/HU with addr[0]=1 is misaligned. W with addr[1:0]!=0 is misaligned.
//  Misaligned access: suppressed (no RAM write, q=0 next cycle); misalign=1 in cycle N+1.
//  Invalid type: no-op; no misalign pulse.
//  sig_load and sig_store both high: the store wins and the load is dropped.
//  Loads:
//   - RAM is read synchronously in cycle N. Type and addr[1:0] are latched in cycle N.
//   - q is valid in cycle N+1, derived combinationally from the RAM output and the latched fields.
//   - Byte lane: byte at offset k -> ram_q[8k+7:8k]. Half lane: addr[1] selects [31:16] or [15:0].
//   - Sign-extend for B/H; zero-extend for BU/HU.
//   - Loads never stall.
//  Word store (SW): written in cycle N; no stall in either mode.
//  Sub-word store, BYTE_EN=1:
//   - Data is replicated across lanes (byte x4, half x2).
//   - Byte enable = one-hot lane (SB) or 2'b11 at the selected half (SH). Written in cycle N; no stall.
//  Sub-word store, BYTE_EN=0, FSM IDLE->MERGE->IDLE:
//   - IDLE, cycle N: issue RAM read of the target word; latch index, offset, size and data.
//   - MERGE, cycle N+1: mem_stall=1 (combinational from state). Merge the latched lanes into ram_q,
//     write the word, return to IDLE.
//   - Inputs are ignored during MERGE; the write uses only latched values.
//   - A load in cycle N+2 to the same word returns the merged data.
//  Back-to-back sub-word stores (BYTE_EN=0): each costs 2 cycles; no state is lost between them.
//  Read-during-write to the same index: read-first; write data is visible from the next cycle on.
//  Reset asserted in MERGE: the pending write is dropped, FSM goes to IDLE, outputs take reset values.
// STRUCTURE
//  Shared package (mem_pkg):
//   - funct3 constants: LS_B, LS_H, LS_W, LS_BU, LS_HU.
//   - FSM state encoding: ST_IDLE, ST_MERGE.
//   - Lane-merge and load-extract functions, reused by the bench model.
//  One sub-module, data_ram_sp: DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte-enable.
//   - For BYTE_EN=0 the enable is tied to 4'hF.
//  The controller holds the FSM, latches, alignment check and load formatting.
// TESTING
//  1. SW 0x8765_4321 @0x10; LW @0x10; LB @0x13; LBU @0x13
//     -> q = 0x8765_4321, 0xFFFF_FF87, 0x0000_0087; no stall.
//  2. (BYTE_EN=0) SW 0 @0x20; SB 0xAB @0x21
//     -> mem_stall=1 exactly one cycle; LW @0x20 then returns 0x0000_AB00.
//  3. (BYTE_EN=0) SH 0xBEEF @0x22 then SH 0x1234 @0x20, back-to-back
//     -> 2 stall cycles total; LW @0x20 = 0xBEEF_1234; LH @0x22 = 0xFFFF_BEEF.
//  4. LW @0x06; SH @0x31
//     -> misalign pulses once each; no write (LW @0x30 unchanged); q=0 after the faulted load.
//  5. Assert rst_n=0 during MERGE of SB 0x55 @0x40 (old word 0)
//     -> mem_stall=0, q=0 immediately; LW @0x40 after reset = 0.
//  6. Rerun 2-3 with BYTE_EN=1 -> identical q values and mem_stall never asserted;
//     addr 0x4000_0010 aliases 0x10 (DEPTH_WORDS=4096).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store definitions: funct3 codes, controller state encoding and
// byte-lane helpers used by the data-memory controller.
package mem_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NB_LANES = 4;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    // Latched sub-word store payload: lane mask plus lane-replicated data
    typedef struct packed {
        logic [NB_LANES-1:0] be;
        logic [XLEN-1:0]     wdata;
    } lane_wr_t;

    function automatic logic is_load_type(input logic [2:0] f);
        return (f == LS_B) || (f == LS_H) || (f == LS_W) || (f == LS_BU) || (f == LS_HU);
    endfunction

    function automatic logic is_store_type(input logic [2:0] f);
        return (f == LS_B) || (f == LS_H) || (f == LS_W);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f, input logic [1:0] off);
        case (f)
            LS_H, LS_HU: return off[0];
            LS_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [NB_LANES-1:0] lane_mask(input logic [2:0] f, input logic [1:0] off);
        case (f)
            LS_B, LS_BU: return 4'b0001 << off;
            LS_H, LS_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:     return 4'hF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicate_lanes(input logic [2:0] f, input logic [XLEN-1:0] d);
        case (f)
            LS_B, LS_BU: return {4{d[7:0]}};
            LS_H, LS_HU: return {2{d[15:0]}};
            default:     return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0]     old_word,
                                                    input logic [XLEN-1:0]     new_word,
                                                    input logic [NB_LANES-1:0] mask);
        logic [XLEN-1:0] w;
        w = old_word;
        for (int b = 0; b < NB_LANES; b++) begin
            if (mask[b]) w[8*b +: 8] = new_word[8*b +: 8];
        end
        return w;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [2:0]      f,
                                                     input logic [1:0]      off);
        logic [7:0]  bt;
        logic [15:0] hw;
        bt = word[{off, 3'b000} +: 8];
        hw = off[1] ? word[31:16] : word[15:0];
        case (f)
            LS_B:    return {{24{bt[7]}}, bt};
            LS_BU:   return {24'd0, bt};
            LS_H:    return {{16{hw[15]}}, hw};
            LS_HU:   return {16'd0, hw};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous word RAM with per-byte write enables; read-first on
// a same-cycle write. Contents are never reset.
module data_ram_sp #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        rdata_o <= mem_q[idx_i];
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32 data-memory controller: load formatting, byte/half/word stores (RMW or
// byte-enabled), misalignment detection, in front of a local word RAM.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = 12,
    parameter bit          BYTE_EN     = 1'b0
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        sig_load,
    input  logic        sig_store,
    input  logic [2:0]  ls_type,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [31:0] q,
    output logic        mem_stall,
    output logic        misalign
);

    state_e           state_q, state_d;
    logic             ld_pend_q, ld_pend_d;
    logic [2:0]       ld_type_q, ld_type_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic [IDX_W-1:0] st_idx_q, st_idx_d;
    lane_wr_t         st_lane_q, st_lane_d;
    logic             mis_q, mis_d;

    logic             ram_we;
    logic [3:0]       ram_be;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_q;

    logic             do_store, do_load, req_mis, store_ok, load_ok;
    logic [IDX_W-1:0] req_idx;
    logic             addr_unused;

    // Store wins over a simultaneous load; nothing is accepted while merging
    assign do_store    = (state_q == ST_IDLE) && sig_store && is_store_type(ls_type);
    assign do_load     = (state_q == ST_IDLE) && sig_load && !sig_store && is_load_type(ls_type);
    assign req_mis     = (do_store || do_load) && is_misaligned(ls_type, addr[1:0]);
    assign store_ok    = do_store && !req_mis;
    assign load_ok     = do_load && !req_mis;
    assign req_idx     = addr[IDX_W+1:2];
    assign addr_unused = ^{addr[31:IDX_W+2]};

    always_comb begin
        state_d   = ST_IDLE;
        ld_pend_d = 1'b0;
        ld_type_d = ld_type_q;
        ld_off_d  = ld_off_q;
        st_idx_d  = st_idx_q;
        st_lane_d = st_lane_q;
        mis_d     = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_idx   = req_idx;
        ram_wdata = replicate_lanes(ls_type, data);
        if (state_q == ST_MERGE) begin
            ram_we    = 1'b1;
            ram_idx   = st_idx_q;
            ram_wdata = merge_lanes(ram_q, st_lane_q.wdata, st_lane_q.be);
        end else begin
            mis_d = req_mis;
            if (store_ok) begin
                if (BYTE_EN || (ls_type == LS_W)) begin
                    ram_we = 1'b1;
                    ram_be = BYTE_EN ? lane_mask(ls_type, addr[1:0]) : 4'hF;
                end else begin
                    // Sub-word RMW: the read issued now returns the old word in MERGE
                    state_d   = ST_MERGE;
                    st_idx_d  = req_idx;
                    st_lane_d = '{be: lane_mask(ls_type, addr[1:0]),
                                  wdata: replicate_lanes(ls_type, data)};
                end
            end else if (load_ok) begin
                ld_pend_d = 1'b1;
                ld_type_d = ls_type;
                ld_off_d  = addr[1:0];
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ld_pend_q <= 1'b0;
            ld_type_q <= LS_W;
            ld_off_q  <= 2'b00;
            st_idx_q  <= '0;
            st_lane_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_pend_q <= ld_pend_d;
            ld_type_q <= ld_type_d;
            ld_off_q  <= ld_off_d;
            st_idx_q  <= st_idx_d;
            st_lane_q <= st_lane_d;
            mis_q     <= mis_d;
        end
    end

    data_ram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (cpu_clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_q)
    );

    assign q         = ld_pend_q ? load_extract(ram_q, ld_type_q, ld_off_q) : 32'd0;
    assign mem_stall = (state_q == ST_MERGE);
    assign misalign  = mis_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Runs an RMW instance and a byte-enable instance side by side on identical
// traffic and checks both against a byte-array memory model.
module tb_data_mem_ctrl;

    localparam int unsigned MEM_BYTES = 16384;

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        sig_load, sig_store;
    logic [2:0]  ls_type;
    logic [31:0] addr, data;
    logic [31:0] q0, q1;
    logic        stall0, stall1, mis0, mis1;

    int          checks = 0;
    int          errors = 0;
    int          stall0_cycles = 0;
    int          stall1_cycles = 0;
    logic [31:0] last_q;
    logic [7:0]  mem_m [MEM_BYTES];

    always #5 cpu_clk = ~cpu_clk;

    data_mem_ctrl #(.DEPTH_WORDS(4096), .IDX_W(12), .BYTE_EN(1'b0)) u_dut_rmw (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .sig_load(sig_load), .sig_store(sig_store),
        .ls_type(ls_type), .addr(addr), .data(data),
        .q(q0), .mem_stall(stall0), .misalign(mis0));

    data_mem_ctrl #(.DEPTH_WORDS(4096), .IDX_W(12), .BYTE_EN(1'b1)) u_dut_be (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .sig_load(sig_load), .sig_store(sig_store),
        .ls_type(ls_type), .addr(addr), .data(data),
        .q(q1), .mem_stall(stall1), .misalign(mis1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
        int unsigned b;
        logic [31:0] v;
        b = a % MEM_BYTES;
        v = 32'd0;
        case (t)
            3'd0: begin v = 32'(mem_m[b]); if (v >= 128) v = v + 32'hFFFF_FF00; end
            3'd4: v = 32'(mem_m[b]);
            3'd1: begin v = 32'(mem_m[b]) + 256 * 32'(mem_m[b+1]); if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd5: v = 32'(mem_m[b]) + 256 * 32'(mem_m[b+1]);
            3'd2: v = 32'(mem_m[b]) | (32'(mem_m[b+1]) << 8) | (32'(mem_m[b+2]) << 16) | (32'(mem_m[b+3]) << 24);
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        int unsigned b;
        b = a % MEM_BYTES;
        mem_m[b] = d[7:0];
        if (t != 3'd0) mem_m[b+1] = d[15:8];
        if (t == 3'd2) begin
            mem_m[b+2] = d[23:16];
            mem_m[b+3] = d[31:24];
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d);
        sig_load = ld; sig_store = st; ls_type = t; addr = a; data = d;
    endtask

    // One request; for an accepted sub-word store the core holds for the stall cycle
    task automatic op(input logic ld, input logic st, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] d);
        logic vs, vl, mis, sub;
        logic [31:0] exp_q;
        vs  = st && (t == 3'd0 || t == 3'd1 || t == 3'd2);
        vl  = ld && !st && (t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd4 || t == 3'd5);
        mis = 1'b0;
        if (vs || vl) begin
            if ((t == 3'd1 || t == 3'd5) && a[0]) mis = 1'b1;
            if (t == 3'd2 && a[1:0] != 2'b00) mis = 1'b1;
        end
        exp_q = (vl && !mis) ? model_load(t, a) : 32'd0;
        sub   = vs && !mis && (t != 3'd2);
        if (vs && !mis) model_store(t, a, d);
        drive(ld, st, t, a, d);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        last_q = q0;
        if (stall0) stall0_cycles++;
        if (stall1) stall1_cycles++;
        chk("q_rmw", q0, exp_q);
        chk("q_be", q1, exp_q);
        chk("mis_rmw", 32'(mis0), 32'(mis));
        chk("mis_be", 32'(mis1), 32'(mis));
        chk("stall_rmw", 32'(stall0), 32'(sub));
        chk("stall_be", 32'(stall1), 32'd0);
        if (sub) begin
            drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            @(posedge cpu_clk);
            @(negedge cpu_clk);
            if (stall0) stall0_cycles++;
            if (stall1) stall1_cycles++;
            chk("stall_rmw_release", 32'(stall0), 32'd0);
            chk("mis_after_merge", 32'(mis0), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r, a, d;
        logic [2:0]  t;
        int          kind, s0;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge cpu_clk);
        chk("reset_q_rmw", q0, 32'd0);
        chk("reset_q_be", q1, 32'd0);
        chk("reset_stall", 32'({stall0, stall1}), 32'd0);
        chk("reset_mis", 32'({mis0, mis1}), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < 32; w++) op(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom());

        // Word store then formatted loads of its top byte
        op(1'b0, 1'b1, 3'd2, 32'h10, 32'h8765_4321);
        op(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        chk("t1_lw", last_q, 32'h8765_4321);
        op(1'b1, 1'b0, 3'd0, 32'h13, 32'd0);
        chk("t1_lb", last_q, 32'hFFFF_FF87);
        op(1'b1, 1'b0, 3'd4, 32'h13, 32'd0);
        chk("t1_lbu", last_q, 32'h0000_0087);

        // Single byte store through the merge path
        op(1'b0, 1'b1, 3'd2, 32'h20, 32'd0);
        s0 = stall0_cycles;
        op(1'b0, 1'b1, 3'd0, 32'h21, 32'h0000_00AB);
        chk("t2_stall_cycles", 32'(stall0_cycles - s0), 32'd1);
        op(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        chk("t2_lw", last_q, 32'h0000_AB00);

        // Back-to-back half stores into one word
        s0 = stall0_cycles;
        op(1'b0, 1'b1, 3'd1, 32'h22, 32'h0000_BEEF);
        op(1'b0, 1'b1, 3'd1, 32'h20, 32'h0000_1234);
        chk("t3_stall_cycles", 32'(stall0_cycles - s0), 32'd2);
        op(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        chk("t3_lw", last_q, 32'hBEEF_1234);
        op(1'b1, 1'b0, 3'd1, 32'h22, 32'd0);
        chk("t3_lh", last_q, 32'hFFFF_BEEF);

        // Misaligned load and store are both suppressed
        op(1'b0, 1'b1, 3'd2, 32'h30, 32'hCAFE_F00D);
        op(1'b1, 1'b0, 3'd2, 32'h06, 32'd0);
        chk("t4_lw_mis_q", last_q, 32'd0);
        op(1'b0, 1'b1, 3'd1, 32'h31, 32'h0000_7777);
        op(1'b1, 1'b0, 3'd2, 32'h30, 32'd0);
        chk("t4_lw_unchanged", last_q, 32'hCAFE_F00D);

        // Invalid type, and load+store collision
        op(1'b1, 1'b0, 3'd3, 32'h10, 32'd0);
        op(1'b1, 1'b1, 3'd2, 32'h14, 32'h1111_2222);

        // Reset during the merge cycle drops the pending RMW write
        op(1'b0, 1'b1, 3'd2, 32'h40, 32'd0);
        drive(1'b0, 1'b1, 3'd0, 32'h40, 32'h0000_0055);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("t5_in_merge", 32'(stall0), 32'd1);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stall", 32'(stall0), 32'd0);
        chk("t5_rst_q", q0, 32'd0);
        chk("t5_rst_q_be", q1, 32'd0);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 32'h40, 32'd0);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("t5_lw_rmw", q0, 32'd0);
        chk("t5_lw_be", q1, 32'h0000_0055);
        op(1'b0, 1'b1, 3'd2, 32'h40, 32'd0);

        // High address bits alias onto the same word
        op(1'b0, 1'b1, 3'd2, 32'h4000_0010, 32'h1357_2468);
        op(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        chk("t6_alias", last_q, 32'h1357_2468);

        // Random traffic over the initialised window, random upper address bits
        for (int i = 0; i < 400; i++) begin
            r    = $urandom();
            a    = r & 32'hFFFF_C07F;
            d    = $urandom();
            kind = $urandom_range(0, 9);
            t    = 3'($urandom_range(0, 7));
            if (kind < 4)       op(1'b1, 1'b0, t, a, d);
            else if (kind < 8)  op(1'b0, 1'b1, t & 3'b011, a, d);
            else if (kind == 8) op(1'b1, 1'b1, t & 3'b011, a, d);
            else                op(1'b0, 1'b0, t, a, d);
        end

        chk("be_never_stalls", 32'(stall1_cycles), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
